// File: rtl/mips_test_pkg.sv
// Shared definitions for the MIPS self-test sequencer.
// Contents: default widths, sequencer state enum, check-kind constants and
// the helper that picks the first phase with nonzero length.
package mips_test_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_CHK_W  = 4;
    localparam int unsigned DEF_CYC_W  = 16;
    localparam int unsigned RF_ADDR_W  = 5;

    localparam logic CHK_RF = 1'b0;
    localparam logic CHK_DM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } st_e;

    // Empty phases are skipped: return the earliest phase that has work.
    function automatic st_e first_phase(input logic has_load,
                                        input logic has_run,
                                        input logic has_chk);
        if (has_load) begin
            return ST_LOAD;
        end else if (has_run) begin
            return ST_RUN;
        end else if (has_chk) begin
            return ST_CHECK;
        end
        return ST_DONE;
    endfunction

endpackage

// File: rtl/selftest_result_log.sv
// Comparator and result log for the self-test check phase.
// Ports: clk/reset (sync, active-high); clear starts a fresh result set;
// valid marks a compare cycle; idx/got/exp_val describe the current check;
// mismatch_c is the combinational compare result; err_count saturates at
// all-ones; fail_idx/fail_got/fail_exp hold the first mismatch only.
module selftest_result_log #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CHK_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              valid,
    input  logic [CHK_W-1:0]  idx,
    input  logic [DATA_W-1:0] got,
    input  logic [DATA_W-1:0] exp_val,
    output logic              mismatch_c,
    output logic [CHK_W:0]    err_count,
    output logic [CHK_W-1:0]  fail_idx,
    output logic [DATA_W-1:0] fail_got,
    output logic [DATA_W-1:0] fail_exp
);

    assign mismatch_c = valid && (got != exp_val);

    // Error counter with saturation and first-failure capture.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_count <= '0;
            fail_idx  <= '0;
            fail_got  <= '0;
            fail_exp  <= '0;
        end else if (mismatch_c) begin
            if (err_count == '0) begin
                fail_idx <= idx;
                fail_got <= got;
                fail_exp <= exp_val;
            end
            if (err_count != '1) begin
                err_count <= err_count + (CHK_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mips_selftest_ctrl.sv
// Self-test sequencer for the single-cycle MIPS core: loads IMEM from a ROM
// with the core held in reset, runs the core for a set number of cycles, then
// walks a check table against the RF/DMEM debug ports.
// Ports: start/prog_len/run_cycles/chk_count configure a run; prog_addr/
// prog_data read the ROM; imem_* write IMEM; cpu_reset holds the core PC;
// chk_idx/chk_kind/chk_addr/chk_expect read the check table; dbg_* read the
// RF and DMEM; busy/done/pass/err_count/fail_* report the result.
module mips_selftest_ctrl
    import mips_test_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned CHK_W        = DEF_CHK_W,
    parameter int unsigned CYC_W        = DEF_CYC_W,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] prog_len,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic [CHK_W:0]    chk_count,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic [CHK_W-1:0]  chk_idx,
    input  logic              chk_kind,
    input  logic [ADDR_W-1:0] chk_addr,
    input  logic [DATA_W-1:0] chk_expect,
    output logic [4:0]        dbg_rf_addr,
    input  logic [DATA_W-1:0] dbg_rf_data,
    output logic [ADDR_W-1:0] dbg_dm_addr,
    input  logic [DATA_W-1:0] dbg_dm_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CHK_W:0]    err_count,
    output logic [CHK_W-1:0]  fail_idx,
    output logic [DATA_W-1:0] fail_got,
    output logic [DATA_W-1:0] fail_exp
);

    st_e               state;
    st_e               tgt_c;
    logic              adv_c;
    logic [ADDR_W-1:0] len_q;
    logic [CHK_W:0]    nchk_q;
    logic [CYC_W-1:0]  run_cnt;
    logic [ADDR_W:0]   ld_cnt;
    logic              ph_b;
    logic              idle_c;
    logic              clear_c;
    logic              chk_valid_c;
    logic              last_chk_c;
    logic              mismatch_c;
    logic              pass_next_c;
    logic [DATA_W-1:0] got_c;

    // ROM data lands one cycle after its address, aligned with the delayed write strobe.
    assign imem_wdata = prog_data;

    assign idle_c      = (state == ST_IDLE) || (state == ST_DONE);
    assign clear_c     = adv_c && idle_c;
    assign chk_valid_c = (state == ST_CHECK) && ph_b;
    assign last_chk_c  = ({1'b0, chk_idx} + (CHK_W+1)'(1)) == nchk_q;

    // Debug addresses only carry the table address during compare cycles.
    assign dbg_rf_addr = (chk_valid_c && chk_kind == CHK_RF) ? RF_ADDR_W'(chk_addr) : '0;
    assign dbg_dm_addr = (chk_valid_c && chk_kind == CHK_DM) ? chk_addr : '0;
    assign got_c       = (chk_kind == CHK_RF) ? dbg_rf_data : dbg_dm_data;

    // On start the old error count is about to be cleared, so it must not gate pass.
    assign pass_next_c = idle_c || ((err_count == '0) && !mismatch_c);

    // Phase-exit detection and the phase that follows.
    always_comb begin
        adv_c = 1'b0;
        tgt_c = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    adv_c = 1'b1;
                    tgt_c = first_phase(prog_len != '0, run_cycles != '0, chk_count != '0);
                end
            end
            ST_LOAD: begin
                if (ld_cnt == {1'b0, len_q}) begin
                    adv_c = 1'b1;
                    tgt_c = first_phase(1'b0, run_cnt != '0, nchk_q != '0);
                end
            end
            ST_RUN: begin
                if (run_cnt == CYC_W'(1)) begin
                    adv_c = 1'b1;
                    tgt_c = first_phase(1'b0, 1'b0, nchk_q != '0);
                end
            end
            ST_CHECK: begin
                if (ph_b && (last_chk_c || (STOP_ON_FAIL && mismatch_c))) begin
                    adv_c = 1'b1;
                    tgt_c = ST_DONE;
                end
            end
            default: begin
                adv_c = 1'b1;
                tgt_c = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            prog_addr  <= '0;
            chk_idx    <= '0;
            len_q      <= '0;
            nchk_q     <= '0;
            run_cnt    <= '0;
            ld_cnt     <= '0;
            ph_b       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len_q     <= prog_len;
                        nchk_q    <= chk_count;
                        run_cnt   <= run_cycles;
                        prog_addr <= '0;
                        ld_cnt    <= '0;
                        chk_idx   <= '0;
                        ph_b      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // ld_cnt counts address-issue cycles; one extra cycle drains the write.
                    if (ld_cnt != {1'b0, len_q}) begin
                        imem_we    <= 1'b1;
                        imem_waddr <= prog_addr;
                        ld_cnt     <= ld_cnt + (ADDR_W+1)'(1);
                        if ((ld_cnt + (ADDR_W+1)'(1)) < {1'b0, len_q}) begin
                            prog_addr <= prog_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    run_cnt <= run_cnt - CYC_W'(1);
                end
                ST_CHECK: begin
                    if (!ph_b) begin
                        ph_b <= 1'b1;
                    end else begin
                        ph_b <= 1'b0;
                        if (!adv_c) begin
                            chk_idx <= chk_idx + CHK_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (adv_c) begin
                state     <= tgt_c;
                cpu_reset <= (tgt_c != ST_RUN);
                busy      <= (tgt_c == ST_LOAD) || (tgt_c == ST_RUN) || (tgt_c == ST_CHECK);
                done      <= (tgt_c == ST_DONE);
                pass      <= (tgt_c == ST_DONE) && pass_next_c;
            end
        end
    end

    selftest_result_log #(
        .DATA_W (DATA_W),
        .CHK_W  (CHK_W)
    ) u_log (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear_c),
        .valid      (chk_valid_c),
        .idx        (chk_idx),
        .got        (got_c),
        .exp_val    (chk_expect),
        .mismatch_c (mismatch_c),
        .err_count  (err_count),
        .fail_idx   (fail_idx),
        .fail_got   (fail_got),
        .fail_exp   (fail_exp)
    );

endmodule

// File: tb/tb_mips_selftest_ctrl.sv
// Bench for mips_selftest_ctrl: two instances (stop-on-fail and run-all) share
// stimulus; ROM, check table, RF and DMEM are bench-side arrays, and expected
// results come from a sequential walk of the check table.
module tb_mips_selftest_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 4;
    localparam int YW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] prog_len;
    logic [YW-1:0] run_cycles;
    logic [CW:0]   chk_count;

    logic [AW-1:0] prog_addr   [2];
    logic [DW-1:0] prog_data   [2];
    logic          imem_we     [2];
    logic [AW-1:0] imem_waddr  [2];
    logic [DW-1:0] imem_wdata  [2];
    logic          cpu_reset   [2];
    logic [CW-1:0] chk_idx     [2];
    logic          chk_kind    [2];
    logic [AW-1:0] chk_addr    [2];
    logic [DW-1:0] chk_expect  [2];
    logic [4:0]    dbg_rf_addr [2];
    logic [DW-1:0] dbg_rf_data [2];
    logic [AW-1:0] dbg_dm_addr [2];
    logic [DW-1:0] dbg_dm_data [2];
    logic          busy        [2];
    logic          done        [2];
    logic          pass        [2];
    logic [CW:0]   err_count   [2];
    logic [CW-1:0] fail_idx    [2];
    logic [DW-1:0] fail_got    [2];
    logic [DW-1:0] fail_exp    [2];

    // Bench-side memories
    logic [DW-1:0] rom     [256];
    logic [DW-1:0] rf      [32];
    logic [DW-1:0] dm      [256];
    logic          ck_kind [16];
    logic [AW-1:0] ck_addr [16];
    logic [DW-1:0] ck_exp  [16];

    // Monitor state
    logic          mon_clr;
    logic [DW-1:0] imem    [2][256];
    int            wr_cnt  [2];
    int            low_cnt [2];
    int            max_idx [2];
    bit            viol    [2];
    logic [AW-1:0] dm_seen [2];

    // Expected results (index 0 = stop on fail, 1 = run all)
    int            e_lat  [2];
    int            e_err  [2];
    int            e_fidx [2];
    int            e_exec [2];
    logic [DW-1:0] e_fgot [2];
    logic [DW-1:0] e_fexp [2];
    bit            e_pass [2];
    int            l_obs  [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mips_selftest_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CHK_W(CW), .CYC_W(YW), .STOP_ON_FAIL(1'b1)) u_stop (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .run_cycles(run_cycles),
        .chk_count(chk_count), .prog_addr(prog_addr[0]), .prog_data(prog_data[0]),
        .imem_we(imem_we[0]), .imem_waddr(imem_waddr[0]), .imem_wdata(imem_wdata[0]),
        .cpu_reset(cpu_reset[0]), .chk_idx(chk_idx[0]), .chk_kind(chk_kind[0]),
        .chk_addr(chk_addr[0]), .chk_expect(chk_expect[0]), .dbg_rf_addr(dbg_rf_addr[0]),
        .dbg_rf_data(dbg_rf_data[0]), .dbg_dm_addr(dbg_dm_addr[0]), .dbg_dm_data(dbg_dm_data[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
        .fail_idx(fail_idx[0]), .fail_got(fail_got[0]), .fail_exp(fail_exp[0])
    );

    mips_selftest_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CHK_W(CW), .CYC_W(YW), .STOP_ON_FAIL(1'b0)) u_all (
        .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .run_cycles(run_cycles),
        .chk_count(chk_count), .prog_addr(prog_addr[1]), .prog_data(prog_data[1]),
        .imem_we(imem_we[1]), .imem_waddr(imem_waddr[1]), .imem_wdata(imem_wdata[1]),
        .cpu_reset(cpu_reset[1]), .chk_idx(chk_idx[1]), .chk_kind(chk_kind[1]),
        .chk_addr(chk_addr[1]), .chk_expect(chk_expect[1]), .dbg_rf_addr(dbg_rf_addr[1]),
        .dbg_rf_data(dbg_rf_data[1]), .dbg_dm_addr(dbg_dm_addr[1]), .dbg_dm_data(dbg_dm_data[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
        .fail_idx(fail_idx[1]), .fail_got(fail_got[1]), .fail_exp(fail_exp[1])
    );

    // Synchronous ROM and check table (1-cycle latency)
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prog_data[i]  <= rom[prog_addr[i]];
            chk_kind[i]   <= ck_kind[chk_idx[i]];
            chk_addr[i]   <= ck_addr[chk_idx[i]];
            chk_expect[i] <= ck_exp[chk_idx[i]];
        end
    end

    // Combinational debug read ports
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dbg_rf_data[i] = rf[dbg_rf_addr[i]];
            dbg_dm_data[i] = dm[dbg_dm_addr[i]];
        end
    end

    // Mid-cycle observer: IMEM image, write count, core-run cycles, issued checks
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_clr) begin
                wr_cnt[i]  <= 0;
                low_cnt[i] <= 0;
                max_idx[i] <= 0;
                viol[i]    <= 1'b0;
                dm_seen[i] <= '0;
                for (int a = 0; a < 256; a++) imem[i][a] <= '1;
            end else begin
                if (imem_we[i]) begin
                    imem[i][imem_waddr[i]] <= imem_wdata[i];
                    wr_cnt[i] <= wr_cnt[i] + 1;
                    if (!cpu_reset[i]) viol[i] <= 1'b1;
                end
                if (!cpu_reset[i]) low_cnt[i] <= low_cnt[i] + 1;
                if (busy[i] && int'(chk_idx[i]) > max_idx[i]) max_idx[i] <= int'(chk_idx[i]);
                if (dbg_dm_addr[i] != '0) dm_seen[i] <= dbg_dm_addr[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Sequential walk of the check table for both stop policies.
    task automatic model(input int len, input int r, input int c);
        int errs;
        int fi;
        int ex;
        logic [DW-1:0] fg;
        logic [DW-1:0] fe;
        logic [DW-1:0] got;
        logic [AW-1:0] a;
        for (int s = 0; s < 2; s++) begin
            errs = 0; fi = 0; ex = 0; fg = '0; fe = '0;
            for (int k = 0; k < c; k++) begin
                ex++;
                a = ck_addr[k];
                got = ck_kind[k] ? dm[a] : rf[a[4:0]];
                if (got != ck_exp[k]) begin
                    if (errs == 0) begin
                        fi = k; fg = got; fe = ck_exp[k];
                    end
                    errs++;
                    if (s == 0) break;
                end
            end
            e_lat[s]  = ((len != 0) ? len + 1 : 0) + r + 2 * ex;
            e_err[s]  = errs;
            e_fidx[s] = fi;
            e_fgot[s] = fg;
            e_fexp[s] = fe;
            e_exec[s] = ex;
            e_pass[s] = (errs == 0);
        end
    endtask

    task automatic fill_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom;
            dm[i]  = $urandom;
        end
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int k = 0; k < 16; k++) begin
            ck_kind[k] = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, 255));
            ck_addr[k] = a;
            ck_exp[k] = ck_kind[k] ? dm[a] : rf[a[4:0]];
            if ($urandom_range(0, 2) == 0) ck_exp[k] = ck_exp[k] ^ (32'h1 << $urandom_range(0, 31));
        end
    endtask

    // One full sequence on both instances, checked against the model.
    task automatic run_seq(input int len, input int r, input int c, input int poke);
        bit seen [2];
        int bad;
        int n;
        model(len, r, c);
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
        prog_len = AW'(len); run_cycles = YW'(r); chk_count = (CW+1)'(c);
        start = 1'b1;
        seen[0] = 1'b0; seen[1] = 1'b0;
        l_obs[0] = -1; l_obs[1] = -1;
        n = 1;
        while (n <= 400 && !(seen[0] && seen[1])) begin
            @(posedge clk); #1;
            start = (n == poke);
            for (int i = 0; i < 2; i++) begin
                if (n == 1) chk($sformatf("busy_after_start[%0d]", i), 64'(busy[i]), 64'(e_lat[i] != 0));
                if (!seen[i] && done[i]) begin
                    seen[i] = 1'b1;
                    l_obs[i] = n - 1;
                end
            end
            n++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("latency[%0d]", i), 64'(l_obs[i]), 64'(e_lat[i]));
            chk($sformatf("done_held[%0d]", i), 64'(done[i]), 64'(1));
            chk($sformatf("busy_done[%0d]", i), 64'(busy[i]), 64'(0));
            chk($sformatf("pass[%0d]", i), 64'(pass[i]), 64'(e_pass[i]));
            chk($sformatf("err_count[%0d]", i), 64'(err_count[i]), 64'(e_err[i]));
            chk($sformatf("fail_idx[%0d]", i), 64'(fail_idx[i]), 64'(e_fidx[i]));
            chk($sformatf("fail_got[%0d]", i), 64'(fail_got[i]), 64'(e_fgot[i]));
            chk($sformatf("fail_exp[%0d]", i), 64'(fail_exp[i]), 64'(e_fexp[i]));
            chk($sformatf("cpu_reset_done[%0d]", i), 64'(cpu_reset[i]), 64'(1));
            chk($sformatf("run_cycles_seen[%0d]", i), 64'(low_cnt[i]), 64'(r));
            chk($sformatf("we_during_run[%0d]", i), 64'(viol[i]), 64'(0));
            chk($sformatf("imem_writes[%0d]", i), 64'(wr_cnt[i]), 64'(len));
            bad = 0;
            for (int a = 0; a < len; a++) if (imem[i][a] !== rom[a]) bad++;
            chk($sformatf("imem_image[%0d]", i), 64'(bad), 64'(0));
            chk($sformatf("last_chk_issued[%0d]", i), 64'(max_idx[i]),
                64'((e_exec[i] != 0) ? e_exec[i] - 1 : 0));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_cpu_reset[%0d]", tag, i), 64'(cpu_reset[i]), 64'(1));
            chk($sformatf("%s_busy[%0d]", tag, i), 64'(busy[i]), 64'(0));
            chk($sformatf("%s_done[%0d]", tag, i), 64'(done[i]), 64'(0));
            chk($sformatf("%s_pass[%0d]", tag, i), 64'(pass[i]), 64'(0));
            chk($sformatf("%s_imem_we[%0d]", tag, i), 64'(imem_we[i]), 64'(0));
            chk($sformatf("%s_prog_addr[%0d]", tag, i), 64'(prog_addr[i]), 64'(0));
            chk($sformatf("%s_chk_idx[%0d]", tag, i), 64'(chk_idx[i]), 64'(0));
            chk($sformatf("%s_dbg_addrs[%0d]", tag, i), 64'({dbg_rf_addr[i], dbg_dm_addr[i]}), 64'(0));
            chk($sformatf("%s_err[%0d]", tag, i), 64'(err_count[i]), 64'(0));
            chk($sformatf("%s_fail[%0d]", tag, i), 64'({fail_idx[i], fail_got[i], fail_exp[i]}), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; mon_clr = 1'b1;
        prog_len = '0; run_cycles = '0; chk_count = '0;
        fill_random();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; mon_clr = 1'b0;
        chk_reset_state("por");

        // Three-word program, five run cycles, two matching checks
        fill_random();
        for (int k = 0; k < 2; k++) ck_exp[k] = ck_kind[k] ? dm[ck_addr[k]] : rf[ck_addr[k][4:0]];
        run_seq(3, 5, 2, 5);
        chk("t1_latency13", 64'(l_obs[0]), 64'(13));
        chk("t1_pass", 64'(pass[0]), 64'(1));

        // Check 1 (RF) and check 2 (DMEM) mismatch
        ck_kind[0] = 1'b0; ck_addr[0] = 8'd3; ck_exp[0] = rf[3];
        rf[7] = 32'h29;
        ck_kind[1] = 1'b0; ck_addr[1] = 8'd7; ck_exp[1] = 32'h2A;
        ck_kind[2] = 1'b1; ck_addr[2] = 8'd9; ck_exp[2] = dm[9] ^ 32'h1;
        run_seq(3, 5, 3, 0);
        chk("t2_stop_err", 64'(err_count[0]), 64'(1));
        chk("t2_stop_fidx", 64'(fail_idx[0]), 64'(1));
        chk("t2_stop_got", 64'(fail_got[0]), 64'(32'h29));
        chk("t2_stop_exp", 64'(fail_exp[0]), 64'(32'h2A));
        chk("t2_stop_issued", 64'(max_idx[0]), 64'(1));
        chk("t2_all_err", 64'(err_count[1]), 64'(2));
        chk("t2_all_fidx", 64'(fail_idx[1]), 64'(1));
        chk("t2_all_issued", 64'(max_idx[1]), 64'(2));

        // DMEM check routed on the debug port
        dm[5] = 32'hABCDEF12;
        ck_kind[0] = 1'b1; ck_addr[0] = 8'd5; ck_exp[0] = 32'hABCDEF12;
        run_seq(0, 2, 1, 0);
        chk("t3_dm_addr", 64'(dm_seen[0]), 64'(5));
        chk("t3_pass", 64'(pass[0]), 64'(1));

        // All phases empty
        run_seq(0, 0, 0, 0);
        chk("t4_latency0", 64'(l_obs[1]), 64'(0));

        // Reset during the third RUN cycle
        prog_len = 8'd2; run_cycles = 16'd8; chk_count = 5'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (cpu_reset[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_run_reached", 64'(cpu_reset[0]), 64'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_reset_state("midrst");
        fill_random();
        run_seq(3, 5, 2, 0);

        // Reset wins over a coincident start
        prog_len = 8'd2; run_cycles = 16'd3; chk_count = 5'd1;
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk_reset_state("rst_start");

        // Randomized sequences
        for (int t = 0; t < 8; t++) begin
            fill_random();
            run_seq(int'($urandom_range(0, 12)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 16)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
